// File: rtl/mul_dsp_sched.sv
// Round-robin issue scheduler for the shared DSP multiplier array, with credit-gated issue,
// a valid/ID tracking pipe and a flush/drain sequence. Perf counters need MUL_DSP_SCHED_PERF_EN.
module mul_dsp_sched #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned NUM_TERMS   = 72,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned CREDITS     = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [NUM_REQ-1:0]                      i_req_valid,
  output logic [NUM_REQ-1:0]                      o_req_ready,
  input  logic [NUM_REQ*WORD_WIDTH*NUM_TERMS-1:0] i_req_a,
  input  logic [NUM_REQ*WORD_WIDTH*NUM_TERMS-1:0] i_req_b,
  output logic [WORD_WIDTH*NUM_TERMS-1:0]         o_mul_a,
  output logic [WORD_WIDTH*NUM_TERMS-1:0]         o_mul_b,
  input  logic [WORD_WIDTH*NUM_TERMS-1:0]         i_mul_products,
  output logic                                    o_res_valid,
  output logic [$clog2(NUM_REQ)-1:0]              o_res_id,
  output logic [WORD_WIDTH*NUM_TERMS-1:0]         o_res_products,
  input  logic                                    i_credit,
  input  logic                                    i_flush,
  output logic                                    o_flush_done,
  output logic                                    o_busy,
  output logic                                    o_credit_err,
  output logic [31:0]                             o_issue_count,
  output logic [31:0]                             o_stall_count
);

  localparam int unsigned SliceW = WORD_WIDTH * NUM_TERMS;
  localparam int unsigned Depth  = MUL_LATENCY + 1;
  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned CntW   = $clog2(CREDITS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CREDITS);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                 state_q;
  logic                   flush_done_q;
  logic [SliceW-1:0]      mul_a_q, mul_a_d;
  logic [SliceW-1:0]      mul_b_q, mul_b_d;
  logic [Depth-1:0]       vld_q, vld_d;
  logic [IdW-1:0]         id_q [Depth];
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdW-1:0]         ptr_q, ptr_d;
  logic                   err_q, err_d;

  logic                   can_grant;
  logic                   grant_found;
  logic [IdW-1:0]         grant_idx;
  logic                   issue;
  logic                   busy;

  // Grant is withheld while reset is held so ready reads 0 during reset.
  assign can_grant = (state_q == StRun) && (cnt_q != '0) && !i_rst;
  assign busy      = |vld_q;

  // Search starting at the round-robin pointer, wrapping past NUM_REQ-1.
  always_comb begin : p_arb
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= int'(NUM_REQ)) begin
        idx = idx - int'(NUM_REQ);
      end
      if (!grant_found && i_req_valid[IdW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IdW'(idx);
      end
    end
  end

  assign issue = can_grant && grant_found;

  always_comb begin
    o_req_ready = '0;
    if (issue) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      if (issue && (grant_idx == IdW'(r))) begin
        mul_a_d = i_req_a[r*SliceW +: SliceW];
        mul_b_d = i_req_b[r*SliceW +: SliceW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);
    end
  end

  // Same-cycle issue and credit return cancel; a surplus credit is flagged, not counted.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (issue && !i_credit) begin
      cnt_d = cnt_q - CntW'(1);
    end else if (!issue && i_credit) begin
      if (cnt_q == CntMax) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign vld_d = {vld_q[Depth-2:0], issue};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      vld_q   <= '0;
      cnt_q   <= CntMax;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        id_q[i] <= '0;
      end
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      id_q[0] <= grant_idx;
      for (int i = 1; i < int'(Depth); i++) begin
        id_q[i] <= id_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StRun;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (i_flush) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!busy) begin
            state_q      <= StDone;
            flush_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= i_flush ? StDrain : StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

`ifdef MUL_DSP_SCHED_PERF_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if ((state_q == StRun) && (|i_req_valid) && (cnt_q == '0)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_issue_count = issue_cnt_q;
  assign o_stall_count = stall_cnt_q;
`else
  assign o_issue_count = 32'd0;
  assign o_stall_count = 32'd0;
`endif

  assign o_mul_a        = mul_a_q;
  assign o_mul_b        = mul_b_q;
  assign o_res_valid    = vld_q[Depth-1];
  assign o_res_id       = id_q[Depth-1];
  assign o_res_products = i_mul_products;
  assign o_flush_done   = flush_done_q;
  assign o_busy         = busy;
  assign o_credit_err   = err_q;

endmodule

// File: tb/tb_mul_dsp_sched.sv
// Bench for mul_dsp_sched: cycle table for grant/credit behaviour, scoreboard for tagged
// products, plus hand sequences for flush/drain and asynchronous reset.
module tb_mul_dsp_sched;

  localparam int W   = 8;
  localparam int T   = 72;
  localparam int NR  = 2;
  localparam int SW  = W * T;
  localparam int IdW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*SW-1:0]  req_a, req_b;
  logic [SW-1:0]     mul_a, mul_b;
  logic [SW-1:0]     mul_p;
  logic              res_valid;
  logic [IdW-1:0]    res_id;
  logic [SW-1:0]     res_p;
  logic              credit, flush;
  logic              flush_done, busy, credit_err;
  logic [31:0]       issue_count, stall_count;

  always #5 clk = ~clk;

  mul_dsp_sched #(
    .WORD_WIDTH (W),
    .NUM_TERMS  (T),
    .MUL_LATENCY(3),
    .NUM_REQ    (NR),
    .CREDITS    (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .i_mul_products(mul_p),
    .o_res_valid   (res_valid),
    .o_res_id      (res_id),
    .o_res_products(res_p),
    .i_credit      (credit),
    .i_flush       (flush),
    .o_flush_done  (flush_done),
    .o_busy        (busy),
    .o_credit_err  (credit_err),
    .o_issue_count (issue_count),
    .o_stall_count (stall_count)
  );

  function automatic logic [SW-1:0] prod(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] p;
    for (int t = 0; t < T; t++) begin
      p[t*W +: W] = a[t*W +: W] * b[t*W +: W];
    end
    return p;
  endfunction

  // Three-stage multiplier array model
  logic [SW-1:0] m1, m2, m3;
  always @(posedge clk) begin
    m1 <= prod(mul_a, mul_b);
    m2 <= m1;
    m3 <= m2;
  end
  assign mul_p = m3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [IdW-1:0] id;
    logic [SW-1:0]  p;
    int             due;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          e.id  = IdW'(r);
          e.p   = prod(req_a[r*SW +: SW], req_b[r*SW +: SW]);
          e.due = cyc + 4;
          sb.push_back(e);
        end
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got res_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_latency", cyc, e.due);
          checks++;
          if (res_p !== e.p) begin
            errors++;
            $display("FAIL res_products: got %h expected %h", res_p, e.p);
          end
        end
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic c, input logic f);
    @(posedge clk);
    #1;
    req_valid = v;
    credit    = c;
    flush     = f;
    for (int i = 0; i < NR * SW / 32; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
  endtask

  typedef struct {
    logic [1:0] vld;
    logic       cr;
    logic [1:0] rdy;
    logic       rv;
    logic       err;
  } vec_t;

  vec_t tbl[25];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_busy;
    int done_cyc;
    int pulses;

    // {valid, credit, expected ready, expected res_valid, expected credit_err}
    tbl[0]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[12] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[13] = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[14] = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[16] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b0};
    tbl[17] = '{2'b11, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[18] = '{2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[19] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[20] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[21] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[22] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[23] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[24] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1};

    rst       = 1'b1;
    req_valid = 2'b11;
    credit    = 1'b0;
    flush     = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_a", mul_a[31:0], 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_credit_err", 32'(credit_err), 32'd0);
    chk("rst_issue_count", issue_count, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    req_valid = 2'b00;
    #1;
    rst = 1'b0;

    for (int k = 0; k < 25; k++) begin
      step(tbl[k].vld, tbl[k].cr, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_res_valid", k), 32'(res_valid), 32'(tbl[k].rv));
      chk($sformatf("tbl%0d_credit_err", k), 32'(credit_err), 32'(tbl[k].err));
    end

`ifdef MUL_DSP_SCHED_PERF_EN
    chk("perf_issue_count", issue_count, 32'd11);
    chk("perf_stall_count", stall_count, 32'd6);
`else
    chk("perf_issue_count_off", issue_count, 32'd0);
    chk("perf_stall_count_off", stall_count, 32'd0);
`endif

    // Flush after three issues
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0, 1'b0);
      @(negedge clk);
      chk("flush_pre_ready", 32'(req_ready), 32'b01);
    end
    step(2'b00, 1'b0, 1'b1);
    @(negedge clk);
    last_busy = -1;
    done_cyc  = -1;
    pulses    = 0;
    for (int i = 0; i < 20 && done_cyc < 0; i++) begin
      step(2'b01, 1'b0, 1'b0);
      @(negedge clk);
      if (busy) last_busy = cyc;
      chk("drain_ready", 32'(req_ready), 32'd0);
      if (flush_done) begin
        pulses++;
        done_cyc = cyc;
      end
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL flush_done_timeout: got no pulse expected one within 20 cycles");
    end else begin
      chk("done_after_busy", done_cyc, last_busy + 2);
    end
    step(2'b01, 1'b0, 1'b0);
    @(negedge clk);
    if (flush_done) pulses++;
    chk("done_pulses", pulses, 32'd1);
    chk("ready_after_done", 32'(req_ready), 32'b01);

    // Two items in flight, then asynchronous reset
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_seq_issue0", 32'(req_ready), 32'b01);
    step(2'b01, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_seq_issue1", 32'(req_ready), 32'b01);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_res_valid", 32'(res_valid), 32'd1);
    @(posedge clk);
    #3;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_res_valid", 32'(res_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_credit_err", 32'(credit_err), 32'd0);
    chk("post_rst_issue_count", issue_count, 32'd0);

    // Pointer back at 0, four credits available
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("post_rst_grant%0d", i), 32'(req_ready),
          (i == 4) ? 32'd0 : ((i % 2 == 0) ? 32'b01 : 32'b10));
    end
    for (int i = 0; i < 6; i++) begin
      step(2'b00, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
